uart_rx_hex2axis: RTL
=====================

// Module: uart_rx_hex2axis
// PURPOSE
// - Upstream companion of the AXI-stream-to-UART hex printer. Receives 8N1 UART bytes carrying
//   ASCII hex text and emits one AXI-stream word per hex token; a line end closes the packet (tlast).
// - Sits between the board UART RX pin and the AXI-stream consumer (e.g. the DDR command stage).
// - Its text format matches the TX side's output, so printed lines loop back unchanged.
// PARAMETERS
// - CLK_DIV     434  aclk cycles per UART bit (>=4)
// - DATA_WIDTH  32   tdata width; TOK_DIGITS=(DATA_WIDTH+3)/4
// - FIFO_ASIZE  4    log2 output FIFO depth; usable depth 2**FIFO_ASIZE-1
// PORTS
// - aclk       in   1           clock
// - aresetn    in   1           reset, asynchronous, active-low
// - uart_rx    in   1           async serial input, idle high
// - tvalid     out  1           AXI-stream master valid
// - tready     in   1           AXI-stream master ready
// - tlast      out  1           last word of a text line
// - tdata      out  DATA_WIDTH  parsed word
// - frame_err  out  1           1-cycle pulse: stop bit sampled 0
// - char_err   out  1           1-cycle pulse: illegal character
// - ovf_err    out  1           1-cycle pulse: word dropped, FIFO full
// BEHAVIOUR
// - Reset: all outputs 0; RX FSM IDLE; accumulator, digit count, pending flag and FIFO pointers clear.
// - Sync: uart_rx passes through a 2-FF synchroniser (reset value 1) before any use.
// - RX FSM IDLE->START on synced 1->0. START: at CLK_DIV/2 cycles, re-sample.
//   1 -> IDLE (glitch, no error); 0 -> DATA.
// - DATA: 8 samples, CLK_DIV apart, LSB first. STOP: one further sample, then IDLE.
//   1 -> byte_valid pulse; 0 -> frame_err pulse, byte discarded.
// - Parser handles one byte per byte_valid:
//   hex digit 0-9/A-F/a-f: acc<=(acc<<4)|val truncated to DATA_WIDTH, dcnt++ (saturating).
//   More than TOK_DIGITS digits keeps the low-order digits.
// - Space, TAB or ',': if dcnt>0, the token is complete. Any pending word is pushed with tlast=0.
//   The new token becomes pending. acc and dcnt then clear.
// - '\n' or '\r': if dcnt>0, the token completes first (same as above).
//   Pending is then pushed with tlast=1 and pending clears. With no pending word, nothing is pushed.
//   So CRLF and blank lines never create empty packets.
// - Any other byte: char_err pulse; acc and dcnt clear; pending is kept.
// - One-word lookahead: a word is not pushed until the next token or line end is seen.
// - FIFO push when full: word dropped, ovf_err pulse, parser continues. Pushes are in order.
//   A dropped tlast word is not regenerated.
// - Output: FWFT FIFO; tdata/tlast stable while tvalid&~tready; pop on tvalid&tready.
//   tvalid rises <=3 aclk after the byte_valid that caused the push.
//   Push and pop may occur in the same cycle when full; the pop frees a slot first, so no overflow.
// - Reset mid-byte or mid-line: everything discarded; the RX FSM needs idle-high before the next start.
// - Pulse outputs are registered. Throughput is limited only by the UART bit rate.
// TESTING (CLK_DIV=8, DATA_WIDTH=32, FIFO_ASIZE=2, tready=1 unless stated)
// - "12AB 34\n" -> 0x000012AB tlast=0, then 0x00000034 tlast=1; no error pulses.
// - "123456789\r\n" -> single word 0x23456789 tlast=1. "\n\n" alone -> no beats.
// - "1G2\n" -> one char_err pulse at the 'G' byte; single word 0x00000002 tlast=1.
// - Byte 0x31 with stop bit 0, then "5\n" -> one frame_err pulse; single word 0x5 tlast=1.
// - Start-bit glitch of 2 cycles -> no byte, no error.
// - tready=0, send "1 2 3 4 5\n" -> 3 words held (1,2,3); 2 ovf_err pulses.
//   Raise tready -> 1,2,3 delivered in order, all tlast=0; tdata stable while stalled.
// - aresetn low mid-byte of "AB" -> no output. After release, "7\n" -> 0x7 tlast=1.

Source files
------------

// File: rtl/uart_rx_hex2axis.sv
// uart_rx_hex2axis: receives 8N1 UART bytes carrying ASCII hex text and emits
// one AXI-stream word per hex token. A line end marks the last word of a line
// (tlast). A one-word lookahead lets the line end tag the final word.
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   uart_rx              asynchronous serial input, idle high
//   tvalid/tready/tlast/tdata  AXI-stream master (first-word-fall-through FIFO)
//   frame_err            1-cycle pulse: stop bit sampled low, byte dropped
//   char_err             1-cycle pulse: byte is not hex, separator or line end
//   ovf_err              1-cycle pulse: word dropped because the FIFO was full
module uart_rx_hex2axis #(
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_ASIZE = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  uart_rx,
  output logic                  tvalid,
  input  logic                  tready,
  output logic                  tlast,
  output logic [DATA_WIDTH-1:0] tdata,
  output logic                  frame_err,
  output logic                  char_err,
  output logic                  ovf_err
);

  localparam int unsigned TOK_DIGITS = (DATA_WIDTH + 3) / 4;
  localparam int unsigned HALF       = CLK_DIV / 2;
  localparam int unsigned CW         = $clog2(CLK_DIV);
  localparam int unsigned DCW        = $clog2(TOK_DIGITS + 1);
  localparam int unsigned FA         = FIFO_ASIZE;
  localparam int unsigned DEPTH      = 1 << FIFO_ASIZE;
  localparam int unsigned FULL       = DEPTH - 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

  // Receiver state
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      byte_q, byte_d;
  logic            byte_valid_q, byte_valid_d;
  logic            frame_err_q, frame_err_d;

  // Parser state
  logic [DATA_WIDTH-1:0] acc_q, acc_d, pdata_q, pdata_d;
  logic [DCW-1:0]        dcnt_q, dcnt_d;
  logic                  pend_q, pend_d, flush_q, flush_d;
  logic                  char_err_q, char_err_d;
  logic                  push;
  logic [DATA_WIDTH:0]   wword;

  // FIFO state; entry layout is {last, data}
  logic [DATA_WIDTH:0]   mem_q [DEPTH];
  logic [FA-1:0]         wr_q, wr_d, rd_q, rd_d, count_q, count_d, remain;
  logic                  pop, push_ok;
  logic                  tvalid_q, ovf_err_q;
  logic [DATA_WIDTH:0]   head_q, head_d;

  // Receiver next-state: start re-check at half bit, then full-bit sampling
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_sync_q) state_d = START;
      end
      START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_sync_q ? IDLE : DATA;
        end else cnt_d = cnt_q + CW'(1);
      end
      DATA: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          shreg_d = {rx_sync_q, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else cnt_d = cnt_q + CW'(1);
      end
      STOP: begin
        if (cnt_q == CW'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_sync_q) begin
            byte_valid_d = 1'b1;
            byte_d       = shreg_q;
          end else frame_err_d = 1'b1;
        end else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Parser: a line end completes the token this cycle and flushes the
  // pending word with tlast on the next cycle, so at most one push per cycle.
  always_comb begin
    logic       is_hex;
    logic [3:0] hval;
    acc_d      = acc_q;
    dcnt_d     = dcnt_q;
    pend_d     = pend_q;
    pdata_d    = pdata_q;
    flush_d    = 1'b0;
    char_err_d = 1'b0;
    push       = 1'b0;
    wword      = {1'b0, pdata_q};
    is_hex     = 1'b0;
    hval       = '0;
    if (byte_q >= 8'h30 && byte_q <= 8'h39) begin
      is_hex = 1'b1; hval = 4'(byte_q - 8'h30);
    end else if (byte_q >= 8'h41 && byte_q <= 8'h46) begin
      is_hex = 1'b1; hval = 4'(byte_q - 8'h37);
    end else if (byte_q >= 8'h61 && byte_q <= 8'h66) begin
      is_hex = 1'b1; hval = 4'(byte_q - 8'h57);
    end
    if (flush_q) begin
      if (pend_q) begin
        push   = 1'b1;
        wword  = {1'b1, pdata_q};
        pend_d = 1'b0;
      end
    end else if (byte_valid_q) begin
      if (is_hex) begin
        acc_d = DATA_WIDTH'({acc_q, hval});
        if (dcnt_q != DCW'(TOK_DIGITS)) dcnt_d = dcnt_q + DCW'(1);
      end else if (byte_q == 8'h20 || byte_q == 8'h09 || byte_q == 8'h2C ||
                   byte_q == 8'h0A || byte_q == 8'h0D) begin
        if (dcnt_q != '0) begin
          push    = pend_q;
          pdata_d = acc_q;
          pend_d  = 1'b1;
        end
        acc_d   = '0;
        dcnt_d  = '0;
        flush_d = (byte_q == 8'h0A || byte_q == 8'h0D);
      end else begin
        char_err_d = 1'b1;
        acc_d      = '0;
        dcnt_d     = '0;
      end
    end
  end

  // FIFO control; a pop in the same cycle frees the slot for a push when full
  always_comb begin
    pop     = tvalid_q & tready;
    push_ok = push & ((count_q != FA'(FULL)) | pop);
    wr_d    = wr_q + FA'(push_ok);
    rd_d    = rd_q + FA'(pop);
    count_d = count_q + FA'(push_ok) - FA'(pop);
    remain  = count_q - FA'(pop);
    head_d  = head_q;
    if (count_d != '0) head_d = (remain == '0) ? wword : mem_q[rd_d];
  end

  // FIFO storage needs no reset; the pointers define what is valid
  always_ff @(posedge aclk) begin
    if (push_ok) mem_q[wr_q] <= wword;
  end

  // State registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      acc_q        <= '0;
      dcnt_q       <= '0;
      pend_q       <= 1'b0;
      pdata_q      <= '0;
      flush_q      <= 1'b0;
      char_err_q   <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
      count_q      <= '0;
      tvalid_q     <= 1'b0;
      head_q       <= '0;
      ovf_err_q    <= 1'b0;
    end else begin
      rx_meta_q    <= uart_rx;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      acc_q        <= acc_d;
      dcnt_q       <= dcnt_d;
      pend_q       <= pend_d;
      pdata_q      <= pdata_d;
      flush_q      <= flush_d;
      char_err_q   <= char_err_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      count_q      <= count_d;
      tvalid_q     <= (count_d != '0);
      head_q       <= head_d;
      ovf_err_q    <= push & ~push_ok;
    end
  end

  assign tvalid    = tvalid_q;
  assign tlast     = head_q[DATA_WIDTH];
  assign tdata     = head_q[DATA_WIDTH-1:0];
  assign frame_err = frame_err_q;
  assign char_err  = char_err_q;
  assign ovf_err   = ovf_err_q;

endmodule
